// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin grant of the common data bus to one completed
// reservation station per cycle. The grant path is purely combinational so
// station groups can decode selection in the same cycle; only the rotating
// priority pointer is registered.
// Optional statistics counters are built when CDB_ARB_STATS_EN is defined.
module cdb_arbiter #(
    parameter int unsigned NUM_REQ  = 8,
    parameter int unsigned ID_BASE  = 1,
    parameter logic [31:0] NO_GRANT = '0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               complete,
    input  logic                             bus_stall,
    input  logic                             flush,
    output logic [31:0]                      selection,
    output logic                             sel_load,
    output logic [NUM_REQ-1:0]               grant_vec,
    output logic                             any_pending
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][CNT_W-1:0]    grant_cnt,
    output logic [CNT_W-1:0]                 conflict_cnt,
    output logic [CNT_W-1:0]                 stall_cnt
`endif
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   rr_ptr_d;
    logic [NUM_REQ-1:0] eligible;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   cand;
    logic               found;

    // Requests are masked off entirely while the bus is stalled or flushing.
    always_comb begin
        eligible    = complete & ~{NUM_REQ{flush | bus_stall}};
        any_pending = (|complete) & ~flush;
    end

    // Scan eligible bits starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Drive the grant outputs from the scan result.
    always_comb begin
        sel_load  = found;
        selection = NO_GRANT;
        grant_vec = '0;
        if (found) begin
            selection = ID_BASE + 32'(winner);
            grant_vec = NUM_REQ'(1) << winner;
        end
    end

    // Next pointer: flush restarts at bit 0, a grant moves just past the winner.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (flush) begin
            rr_ptr_d = '0;
        end else if (sel_load) begin
            rr_ptr_d = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    // Pointer register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef CDB_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] grant_cnt_q;
    logic [CNT_W-1:0]              conflict_cnt_q;
    logic [CNT_W-1:0]              stall_cnt_q;

    // Saturating statistics counters; flush deliberately leaves them intact.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt_q    <= '0;
            conflict_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            for (int unsigned s = 0; s < NUM_REQ; s++) begin
                if (grant_vec[s] && (grant_cnt_q[s] != '1)) begin
                    grant_cnt_q[s] <= grant_cnt_q[s] + 1'b1;
                end
            end
            if (($countones(eligible) > 1) && (conflict_cnt_q != '1)) begin
                conflict_cnt_q <= conflict_cnt_q + 1'b1;
            end
            if (bus_stall && (|complete) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign grant_cnt    = grant_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
    assign stall_cnt    = stall_cnt_q;
`endif

    // At most one station may own the bus, and grant_vec tracks sel_load.
    assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant_vec) && (sel_load == (|grant_vec)));

endmodule
